// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic ops, multi-cycle shift and
// shift-add multiply, with a valid/ready handshake on both sides.
module alu_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             zero,
    output logic             carry,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               r_state;
    logic                 r_is_mul;
    logic [WIDTH-1:0]     r_sh;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_mplr;
    logic [CW-1:0]        r_cnt;

    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_dif;
    logic [WIDTH-1:0]     w_f;
    logic                 w_c;
    logic                 w_o;
    logic [CW-1:0]        w_cnt_sh;
    logic [WIDTH-1:0]     w_sh_nxt;
    logic [2*WIDTH-1:0]   w_acc_nxt;

    assign in_ready  = (r_state == IDLE) && !rst;
    assign w_sum     = {1'b0, a} + {1'b0, b};
    assign w_dif     = {1'b0, a} - {1'b0, b};
    assign w_sh_nxt  = {r_sh[WIDTH-2:0], 1'b0};
    assign w_acc_nxt = r_acc + (r_mplr[0] ? r_mcand : '0);

    // Shift count saturates at WIDTH: further shifts cannot change the result
    always_comb begin
        if (32'(b) > 32'(WIDTH))
            w_cnt_sh = CW'(WIDTH);
        else
            w_cnt_sh = CW'(b);
    end

    always_comb begin
        w_f = a;
        w_c = 1'b0;
        w_o = 1'b0;
        unique case (s)
            3'b000: begin
                w_f = w_sum[WIDTH-1:0];
                w_c = w_sum[WIDTH];
                w_o = (a[WIDTH-1] == b[WIDTH-1]) &&
                      (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            3'b001: begin
                w_f = w_dif[WIDTH-1:0];
                w_c = w_dif[WIDTH];
                w_o = (a[WIDTH-1] != b[WIDTH-1]) &&
                      (w_dif[WIDTH-1] != a[WIDTH-1]);
            end
            3'b010:  w_f = a & b;
            3'b011:  w_f = a | b;
            3'b100:  w_f = a ^ b;
            3'b101:  w_f = ~a;
            default: w_f = a;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_is_mul  <= 1'b0;
            r_sh      <= '0;
            r_mcand   <= '0;
            r_acc     <= '0;
            r_mplr    <= '0;
            r_cnt     <= '0;
            out_valid <= 1'b0;
            f         <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        if (s == 3'b110 && b != '0) begin
                            r_sh     <= a;
                            r_cnt    <= w_cnt_sh;
                            r_is_mul <= 1'b0;
                            r_state  <= BUSY;
                        end else if (s == 3'b111) begin
                            r_mcand  <= {{WIDTH{1'b0}}, a};
                            r_mplr   <= b;
                            r_acc    <= '0;
                            r_cnt    <= CW'(WIDTH);
                            r_is_mul <= 1'b1;
                            r_state  <= BUSY;
                        end else begin
                            f         <= w_f;
                            zero      <= (w_f == '0);
                            carry     <= w_c;
                            ovf       <= w_o;
                            out_valid <= 1'b1;
                            r_state   <= DONE;
                        end
                    end
                end
                BUSY: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_is_mul) begin
                        r_acc   <= w_acc_nxt;
                        r_mcand <= r_mcand << 1;
                        r_mplr  <= r_mplr >> 1;
                        if (r_cnt == CW'(1)) begin
                            f         <= w_acc_nxt[WIDTH-1:0];
                            zero      <= (w_acc_nxt[WIDTH-1:0] == '0);
                            carry     <= 1'b0;
                            ovf       <= |w_acc_nxt[2*WIDTH-1:WIDTH];
                            out_valid <= 1'b1;
                            r_state   <= DONE;
                        end
                    end else begin
                        r_sh <= w_sh_nxt;
                        if (r_cnt == CW'(1)) begin
                            f         <= w_sh_nxt;
                            zero      <= (w_sh_nxt == '0);
                            carry     <= r_sh[WIDTH-1];
                            ovf       <= 1'b0;
                            out_valid <= 1'b1;
                            r_state   <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed cases plus random ops against an
// arithmetic reference model.
module tb_alu_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   s;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] f;
    logic         zero;
    logic         carry;
    logic         ovf;

    int n_cmp = 0;
    int n_err = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .s(s), .out_valid(out_valid), .out_ready(out_ready),
        .f(f), .zero(zero), .carry(carry), .ovf(ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sgn(input int x);
        return (x >= (1 << (W - 1))) ? x - (1 << W) : x;
    endfunction

    // Reference: result, zero, carry, ovf and accept-to-valid latency
    function automatic void model(input int x, input int y, input int op,
                                  output int ef, output int ez,
                                  output int ec, output int eo,
                                  output int el);
        int r;
        int n;
        int m;
        m  = (1 << W) - 1;
        ef = 0;
        ec = 0;
        eo = 0;
        el = 1;
        case (op)
            0: begin
                r  = x + y;
                ef = r & m;
                ec = (r > m) ? 1 : 0;
                r  = sgn(x) + sgn(y);
                eo = (r < -(1 << (W-1)) || r >= (1 << (W-1))) ? 1 : 0;
            end
            1: begin
                ef = (x - y) & m;
                ec = (x < y) ? 1 : 0;
                r  = sgn(x) - sgn(y);
                eo = (r < -(1 << (W-1)) || r >= (1 << (W-1))) ? 1 : 0;
            end
            2: ef = x & y;
            3: ef = x | y;
            4: ef = x ^ y;
            5: ef = ~x & m;
            6: begin
                n  = (y < W) ? y : W;
                ef = (x << n) & m;
                ec = (n == 0) ? 0 : ((x >> (W - n)) & 1);
                el = n + 1;
            end
            default: begin
                r  = x * y;
                ef = r & m;
                eo = (r > m) ? 1 : 0;
                el = W + 1;
            end
        endcase
        ez = (ef == 0) ? 1 : 0;
    endfunction

    task automatic run_op(input int x, input int y, input int op,
                          input int stall);
        int ef, ez, ec, eo, el, lat;
        model(x, y, op, ef, ez, ec, eo, el);
        out_ready = (stall > 0) ? 1'b0 : 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (in_ready) break;
            tick();
        end
        chk("in_ready_idle", int'(in_ready), 1);
        a        = x[W-1:0];
        b        = y[W-1:0];
        s        = op[2:0];
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        s        = 3'($urandom);
        lat      = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        chk($sformatf("lat_op%0d", op), lat, el);
        chk($sformatf("f_op%0d_a%0d_b%0d", op, x, y), int'(f), ef);
        chk("zero", int'(zero), ez);
        chk("carry", int'(carry), ec);
        chk("ovf", int'(ovf), eo);
        for (int k = 0; k < stall; k++) begin
            tick();
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_f", int'(f), ef);
        end
        out_ready = 1'b1;
        tick();
        chk("drop_valid", int'(out_valid), 0);
        chk("retain_f", int'(f), ef);
    endtask

    initial begin
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        s         = '0;
        tick();
        chk("rst_in_ready", int'(in_ready), 0);
        tick();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_f", int'(f), 0);
        chk("rst_zero", int'(zero), 0);
        chk("rst_carry", int'(carry), 0);
        chk("rst_ovf", int'(ovf), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", int'(in_ready), 1);

        for (int op = 0; op < 6; op++) run_op(10, 3, op, 0);
        run_op(10, 3, 6, 0);
        run_op(10, 0, 6, 0);
        run_op(10, 3, 7, 0);
        run_op(9, 15, 6, 0);
        run_op(15, 15, 7, 1);
        run_op(0, 0, 7, 0);
        run_op(8, 8, 1, 2);
        run_op(7, 1, 0, 0);

        // Back-pressure with in_valid held and operands toggling
        out_ready = 1'b0;
        a         = 4'b1010;
        b         = 4'b0011;
        s         = 3'b000;
        in_valid  = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("stall_valid", int'(out_valid), 1);
            chk("stall_f", int'(f), 13);
            chk("stall_in_ready", int'(in_ready), 0);
            a = W'($urandom);
            b = W'($urandom);
            tick();
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        tick();
        chk("stall_drop", int'(out_valid), 0);
        chk("stall_keep_f", int'(f), 13);
        tick();
        chk("stall_no_second", int'(out_valid), 0);

        // Reset in the middle of a multiply
        a        = 4'b1010;
        b        = 4'b0011;
        s        = 3'b111;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", int'(in_ready), 0);
        tick();
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_f", int'(f), 0);
        chk("mid_rst_zero", int'(zero), 0);
        chk("mid_rst_carry", int'(carry), 0);
        chk("mid_rst_ovf", int'(ovf), 0);
        rst = 1'b0;
        #1;
        chk("mid_rst_ready", int'(in_ready), 1);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (out_valid) seen = 1;
        end
        chk("no_stale_result", seen, 0);

        for (int i = 0; i < 60; i++)
            run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 7)),
                   (i % 4 == 0) ? int'($urandom_range(1, 3)) : 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 4, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operation request present.
REQ-005 in_ready  output  1  block accepts a request this cycle.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B, or shift count for op 110.
REQ-008 s  input  3  opcode.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer takes result this cycle.
REQ-011 f  output  WIDTH  registered result.
REQ-012 zero  output  1  f == 0.
REQ-013 carry  output  1  carry/borrow/shifted-out bit.
REQ-014 ovf  output  1  signed overflow or product overflow.

Function
REQ-015 FSM states IDLE, BUSY, DONE shall be used; in_ready shall be 1 only in IDLE and 0 while rst is high.
REQ-016 Acceptance shall occur on an edge with in_valid && in_ready; a, b, s shall be captured and later input changes ignored until return to IDLE.
REQ-017 Ops 000 add, 001 sub (a-b), 010 and, 011 or, 100 xor, 101 not a shall complete in 1 cycle: IDLE -> DONE, out_valid high the cycle after acceptance.
REQ-018 Add: f = (a+b) mod 2^WIDTH, carry = carry-out, ovf = two's-complement overflow.
REQ-019 Sub: f = (a-b) mod 2^WIDTH, carry = 1 when a < b unsigned (borrow), ovf = two's-complement overflow.
REQ-020 Logic ops (010-101): carry = 0, ovf = 0.
REQ-021 Op 110 shall shift a left logically one bit per BUSY cycle for min(b, WIDTH) cycles, then DONE; latency = min(b, WIDTH)+1 cycles; b = 0 goes straight to DONE with f = a.
REQ-022 Op 110: carry = last bit shifted out (0 when b = 0), ovf = 0.
REQ-023 Op 111 shall compute an unsigned shift-add multiply over exactly WIDTH BUSY cycles; latency WIDTH+1 cycles.
REQ-024 Op 111: f = low WIDTH bits of product, ovf = 1 when high WIDTH bits nonzero, carry = 0.
REQ-025 zero shall equal (f == 0) for every op and be registered with f.
REQ-026 In DONE, f/zero/carry/ovf/out_valid shall hold stable while out_ready = 0.
REQ-027 On out_valid && out_ready the FSM shall go to IDLE; out_valid shall drop next cycle; f and flags shall retain last values.
REQ-028 No request shall be accepted in the cycle a result is consumed; minimum issue interval is 2 cycles.
REQ-029 in_valid asserted in BUSY or DONE shall have no effect and not be queued.

Reset
REQ-030 With rst high at an edge: state = IDLE, out_valid = 0, f = 0, zero = 0, carry = 0, ovf = 0, internal shift/multiply registers and counter cleared.
REQ-031 Reset in BUSY or DONE shall abandon the operation with no result ever presented; in_ready = 1 the first cycle after rst drops.

Verification (WIDTH = 4, a = 1010, b = 0011, out_ready = 1 unless stated)
REQ-032 Sweep s = 000..101 -> out_valid 1 cycle after accept; f = 1101, 0111, 0010, 1011, 1001, 0101; add carry 0 ovf 0; sub carry 0 ovf 1.
REQ-033 s = 110 -> out_valid 4 cycles after accept, f = 0000, zero = 1, carry = 1, ovf = 0; b = 0000 -> 1 cycle, f = 1010.
REQ-034 s = 111 -> out_valid 5 cycles after accept, f = 1110, ovf = 1, carry = 0, zero = 0.
REQ-035 Add, out_ready = 0 for 3 cycles with in_valid held high and a, b toggling -> f = 1101 stable, in_ready = 0, no second result; out_ready = 1 -> out_valid drops next cycle.
REQ-036 rst pulsed 2 cycles into a multiply -> out_valid = 0, f = 0, all flags 0, in_ready = 1 the cycle after rst drops, no stale result appears.
